// File: rtl/xbar_sched_pkg.sv
// Shared types and width helpers for the crossbar burst scheduler.
package xbar_sched_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } port_sched_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xbar_port_sched.sv
// Per-output-port scheduler: priority requester, round-robin normal requesters,
// burst locking and a starvation guard on consecutive priority wins.
module xbar_port_sched
  import xbar_sched_pkg::*;
#(
  parameter int unsigned NIn         = 8,
  parameter int unsigned StarveLimit = 4,
  localparam int unsigned IdW        = id_width(NIn),
  localparam int unsigned CntW       = id_width(StarveLimit + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [NIn-1:0] req_i,
  input  logic [NIn-1:0] last_i,
  input  logic           prio_req_i,
  output logic [NIn-1:0] grant_o,
  output logic [IdW-1:0] id_o,
  output logic           prio_grant_o,
  output logic           locked_o,
  output logic           starve_override_o
);

  port_sched_state_t state_q, state_d;
  logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]    lock_id_q, lock_id_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [IdW-1:0]    win;
  logic              win_vld;
  logic              prio_ok;
  int unsigned       idx;
  logic [NIn-1:0]    grant;
  logic [IdW-1:0]    id;
  logic              prio_grant;
  logic              sovr;

  // Round-robin search from rr_ptr_q, wrapping modulo NIn (not 2^IdW).
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NIn; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NIn) idx = idx - NIn;
      if (!win_vld && req_i[idx[IdW-1:0]]) begin
        win_vld = 1'b1;
        win     = idx[IdW-1:0];
      end
    end
  end

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign prio_ok = prio_req_i && ((StarveLimit == 0) || (32'(cnt_q) < StarveLimit));

  // Next-state and grant decode.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_id_d  = lock_id_q;
    cnt_d      = cnt_q;
    grant      = '0;
    id         = '0;
    prio_grant = 1'b0;
    sovr       = 1'b0;
    case (state_q)
      StLocked: begin
        if (req_i[lock_id_q]) begin
          grant[lock_id_q] = 1'b1;
          id               = lock_id_q;
          if (last_i[lock_id_q]) state_d = StIdle;
        end else begin
          // Owner dropped or retargeted mid-burst: release without granting.
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (prio_ok) begin
          prio_grant = 1'b1;
          cnt_d      = (|req_i) ? cnt_inc : '0;
        end else if (win_vld) begin
          grant[win] = 1'b1;
          id         = win;
          rr_ptr_d   = (win == IdW'(NIn - 1)) ? '0 : win + 1'b1;
          cnt_d      = '0;
          sovr       = prio_req_i;
          if (!last_i[win]) begin
            state_d   = StLocked;
            lock_id_d = win;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Scheduler state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
      cnt_q     <= cnt_d;
    end
  end

  // Outputs are held low for the whole time reset is asserted.
  assign grant_o           = rst_ni ? grant : '0;
  assign id_o              = rst_ni ? id : '0;
  assign prio_grant_o      = rst_ni & prio_grant;
  assign starve_override_o = rst_ni & sovr;
  assign locked_o          = rst_ni & (state_d == StLocked);

  a_onehot_grant: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(grant_o));
  a_excl_grant:   assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   !(prio_grant_o && (|grant_o)));
  a_lock_no_prio: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   locked_o |-> !prio_grant_o);

endmodule

// File: rtl/crossbar_burst_scheduler.sv
// Crossbar scheduler top: decodes requests per output port, runs one port
// scheduler per output and folds the per-port grants back onto the inputs.
module crossbar_burst_scheduler
  import xbar_sched_pkg::*;
#(
  parameter int unsigned N_IN_PORTS   = 8,
  parameter int unsigned N_OUT_PORTS  = 8,
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned IN_ID_W     = id_width(N_IN_PORTS),
  localparam int unsigned OUT_ID_W    = id_width(N_OUT_PORTS)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [N_IN_PORTS-1:0]             req_i,
  input  logic [N_IN_PORTS*OUT_ID_W-1:0]    req_out_port_i,
  input  logic [N_IN_PORTS-1:0]             req_last_i,
  input  logic [N_OUT_PORTS-1:0]            priority_req_i,
  output logic [N_IN_PORTS-1:0]             grant_o,
  output logic [N_OUT_PORTS-1:0]            priority_grant_o,
  output logic [N_OUT_PORTS-1:0]            grant_out_port_wise_o,
  output logic [N_OUT_PORTS*N_IN_PORTS-1:0] detailed_grant_o,
  output logic [N_OUT_PORTS*IN_ID_W-1:0]    granted_requester_id_o,
  output logic [N_OUT_PORTS-1:0]            locked_o,
  output logic [N_OUT_PORTS-1:0]            starve_override_o
);

  for (genvar o = 0; o < N_OUT_PORTS; o++) begin : g_port
    logic [N_IN_PORTS-1:0] port_req;

    // Inputs whose request targets this output port.
    always_comb begin
      port_req = '0;
      for (int unsigned i = 0; i < N_IN_PORTS; i++) begin
        port_req[i] = req_i[i] && (req_out_port_i[i*OUT_ID_W +: OUT_ID_W] == OUT_ID_W'(o));
      end
    end

    xbar_port_sched #(
      .NIn         (N_IN_PORTS),
      .StarveLimit (STARVE_LIMIT)
    ) u_sched (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .req_i             (port_req),
      .last_i            (req_last_i),
      .prio_req_i        (priority_req_i[o]),
      .grant_o           (detailed_grant_o[o*N_IN_PORTS +: N_IN_PORTS]),
      .id_o              (granted_requester_id_o[o*IN_ID_W +: IN_ID_W]),
      .prio_grant_o      (priority_grant_o[o]),
      .locked_o          (locked_o[o]),
      .starve_override_o (starve_override_o[o])
    );

    assign grant_out_port_wise_o[o] = priority_grant_o[o] |
                                      (|detailed_grant_o[o*N_IN_PORTS +: N_IN_PORTS]);
  end

  // An input targets a single port, so OR-ing across ports never merges grants.
  always_comb begin
    grant_o = '0;
    for (int unsigned o = 0; o < N_OUT_PORTS; o++) begin
      for (int unsigned i = 0; i < N_IN_PORTS; i++) begin
        grant_o[i] = grant_o[i] | detailed_grant_o[o*N_IN_PORTS + i];
      end
    end
  end

endmodule

// File: tb/tb_crossbar_burst_scheduler.sv
// Scoreboard bench for crossbar_burst_scheduler (6 inputs, 8 ports, guard of 3).
module tb_crossbar_burst_scheduler;

  localparam int unsigned NI = 6;
  localparam int unsigned NO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    req;
  logic [17:0]   req_out_port;
  logic [5:0]    req_last;
  logic [7:0]    priority_req;
  logic [5:0]    grant;
  logic [7:0]    priority_grant;
  logic [7:0]    grant_out_port_wise;
  logic [47:0]   detailed_grant;
  logic [23:0]   granted_requester_id;
  logic [7:0]    locked;
  logic [7:0]    starve_override;

  crossbar_burst_scheduler #(
    .N_IN_PORTS   (NI),
    .N_OUT_PORTS  (NO),
    .STARVE_LIMIT (3)
  ) dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .req_i                  (req),
    .req_out_port_i         (req_out_port),
    .req_last_i             (req_last),
    .priority_req_i         (priority_req),
    .grant_o                (grant),
    .priority_grant_o       (priority_grant),
    .grant_out_port_wise_o  (grant_out_port_wise),
    .detailed_grant_o       (detailed_grant),
    .granted_requester_id_o (granted_requester_id),
    .locked_o               (locked),
    .starve_override_o      (starve_override)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [5:0]  g;
    logic [7:0]  pg;
    logic [7:0]  gpw;
    logic [7:0]  lk;
    logic [7:0]  so;
    logic [47:0] det;
    int          pa;
    logic [2:0]  ia;
    int          pb;
    logic [2:0]  ib;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Stimulus staged here, applied just after the next rising edge.
  logic       s_rst_n;
  logic [5:0] s_req;
  logic [5:0] s_last;
  logic [7:0] s_prio;
  int         s_tgt[6];

  function automatic exp_t mk(input string nm, input logic [5:0] g, input logic [7:0] pg,
                              input logic [7:0] gpw, input logic [7:0] lk, input logic [7:0] so,
                              input int pa, input logic [2:0] ia, input int pb,
                              input logic [2:0] ib);
    exp_t e;
    e.nm = nm; e.g = g; e.pg = pg; e.gpw = gpw; e.lk = lk; e.so = so;
    e.pa = pa; e.ia = ia; e.pb = pb; e.ib = ib;
    e.det = '0;
    for (int i = 0; i < 6; i++) if (g[i]) e.det[s_tgt[i]*6 + i] = 1'b1;
    return e;
  endfunction

  task automatic step(input exp_t e);
    @(posedge clk);
    #1;
    rst_n        = s_rst_n;
    req          = s_req;
    req_last     = s_last;
    priority_req = s_prio;
    for (int i = 0; i < 6; i++) req_out_port[i*3 +: 3] = 3'(s_tgt[i]);
    exp_q.push_back(e);
  endtask

  function automatic void chk(input string nm, input string fld, input logic [63:0] act,
                              input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, expv);
    end
  endfunction

  // Monitor: compare every output against the queued expectation each cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.nm, "grant", 64'(grant), 64'(e.g));
      chk(e.nm, "priority_grant", 64'(priority_grant), 64'(e.pg));
      chk(e.nm, "port_wise", 64'(grant_out_port_wise), 64'(e.gpw));
      chk(e.nm, "locked", 64'(locked), 64'(e.lk));
      chk(e.nm, "starve_override", 64'(starve_override), 64'(e.so));
      chk(e.nm, "detailed_grant", 64'(detailed_grant), 64'(e.det));
      chk(e.nm, "id_a", 64'(granted_requester_id[e.pa*3 +: 3]), 64'(e.ia));
      chk(e.nm, "id_b", 64'(granted_requester_id[e.pb*3 +: 3]), 64'(e.ib));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = '0; req_out_port = '0; req_last = '0; priority_req = '0;
    s_rst_n = 1'b0; s_req = 6'h3F; s_last = 6'h3F; s_prio = 8'hFF;
    for (int i = 0; i < 6; i++) s_tgt[i] = 0;

    // Reset held with everything requesting: all outputs low.
    for (int k = 0; k < 3; k++) step(mk("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0));
    s_rst_n = 1'b1;
    step(mk("rst_release", 0, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0));
    s_req = 0; s_prio = 0;
    step(mk("idle0", 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Round robin among inputs 0..2 on port 0.
    s_req = 6'b000111; s_last = 6'h3F;
    for (int k = 0; k < 6; k++) begin
      int w;
      w = k % 3;
      step(mk("rr", 6'(1 << w), 0, 8'h01, 0, 0, 0, 3'(w), 0, 3'(w)));
    end

    // Starvation guard on port 0 against input 2.
    s_req = 6'b000100; s_prio = 8'h01;
    for (int k = 0; k < 3; k++) step(mk("starve_prio", 0, 8'h01, 8'h01, 0, 0, 0, 0, 0, 0));
    step(mk("starve_ovr", 6'h04, 0, 8'h01, 0, 8'h01, 0, 2, 0, 2));
    for (int k = 0; k < 3; k++) step(mk("starve_prio2", 0, 8'h01, 8'h01, 0, 0, 0, 0, 0, 0));
    s_req = 0; s_prio = 0;
    step(mk("idle1", 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Burst on port 3: move rr_ptr past input 0, then input 1 bursts 4 beats.
    s_tgt[0] = 3; s_tgt[1] = 3; s_req = 6'b000001;
    step(mk("burst_pre", 6'h01, 0, 8'h08, 0, 0, 3, 0, 3, 0));
    s_req = 6'b000011; s_last = 6'b111101;
    step(mk("burst_b1", 6'h02, 0, 8'h08, 8'h08, 0, 3, 1, 3, 1));
    s_prio = 8'h08;
    step(mk("burst_b2", 6'h02, 0, 8'h08, 8'h08, 0, 3, 1, 3, 1));
    step(mk("burst_b3", 6'h02, 0, 8'h08, 8'h08, 0, 3, 1, 3, 1));
    s_last = 6'h3F;
    step(mk("burst_b4", 6'h02, 0, 8'h08, 0, 0, 3, 1, 3, 1));
    step(mk("burst_prio", 0, 8'h08, 8'h08, 0, 0, 3, 0, 3, 0));
    s_req = 0; s_prio = 0; s_tgt[0] = 0; s_tgt[1] = 0;
    step(mk("idle2", 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Abort: input 2 bursts on port 1, drops after beat 2; input 3 pending.
    s_tgt[2] = 1; s_tgt[3] = 1; s_req = 6'b001100; s_last = 6'b111011;
    step(mk("abort_b1", 6'h04, 0, 8'h02, 8'h02, 0, 1, 2, 1, 2));
    step(mk("abort_b2", 6'h04, 0, 8'h02, 8'h02, 0, 1, 2, 1, 2));
    s_req = 6'b001000;
    step(mk("abort_drop", 0, 0, 0, 0, 0, 1, 0, 1, 0));
    s_last = 6'h3F;
    step(mk("abort_next", 6'h08, 0, 8'h02, 0, 0, 1, 3, 1, 3));

    // Two ports granting in the same cycle.
    for (int i = 0; i < 6; i++) s_tgt[i] = 0;
    s_tgt[0] = 1; s_tgt[5] = 6; s_req = 6'b100001;
    step(mk("parallel", 6'h21, 0, 8'h42, 0, 0, 1, 0, 6, 5));

    // Wrap of rr pointer past the last (non power of two) input on port 2.
    for (int i = 0; i < 6; i++) s_tgt[i] = 0;
    s_tgt[4] = 2; s_tgt[5] = 2; s_req = 6'b110000;
    step(mk("wrap_a", 6'h10, 0, 8'h04, 0, 0, 2, 4, 2, 4));
    step(mk("wrap_b", 6'h20, 0, 8'h04, 0, 0, 2, 5, 2, 5));
    step(mk("wrap_c", 6'h10, 0, 8'h04, 0, 0, 2, 4, 2, 4));
    s_req = 0;
    step(mk("idle3", 0, 0, 0, 0, 0, 0, 0, 0, 0));

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("end", "queue_left", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
